// File: rtl/nn_pkg.sv
// Shared definitions for the digit-recognition datapath: canvas geometry,
// probability vector layout and the inference sequencer state encoding.
package nn_pkg;

    localparam int DIM            = 28;
    localparam int NUM_PIX        = DIM * DIM;
    localparam int PIX_W          = 16;
    localparam int NUM_CLASSES    = 10;
    localparam int PROB_W         = 16;
    localparam int TIMEOUT_CYCLES = 1048576;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_NN,
        ARGMAX
    } seq_state_t;

    // Class k lives in element k, i.e. bits [k*PROB_W +: PROB_W] when flattened.
    typedef logic [NUM_CLASSES-1:0][PROB_W-1:0] prob_vec_t;

endpackage

// File: rtl/prob_argmax.sv
// Sequential argmax over a packed probability vector: one class per cycle,
// unsigned compare, ties resolve to the lowest class index.
module prob_argmax #(
    parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter int PROB_W      = nn_pkg::PROB_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_CLASSES*PROB_W-1:0] prob,
    output logic                          done,
    output logic [3:0]                    index,
    output logic [PROB_W-1:0]             value
);

    localparam logic [3:0] LAST_CLS = 4'(NUM_CLASSES - 1);

    logic              running;
    logic [3:0]        cls;
    logic [3:0]        best_idx;
    logic [PROB_W-1:0] best_val;
    logic [PROB_W-1:0] cur_val;
    logic              cur_wins;

    always_comb begin
        cur_val = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (cls == 4'(k)) begin
                cur_val = prob[k*PROB_W +: PROB_W];
            end
        end
    end

    // Strictly greater only, so an equal later class never displaces the best.
    assign cur_wins = (cur_val > best_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running  <= 1'b0;
            cls      <= '0;
            best_idx <= '0;
            best_val <= '0;
        end else if (start) begin
            running  <= 1'b1;
            cls      <= 4'd1;
            best_idx <= '0;
            best_val <= prob[PROB_W-1:0];
        end else if (running) begin
            if (cur_wins) begin
                best_idx <= cls;
                best_val <= cur_val;
            end
            if (cls == LAST_CLS) begin
                running <= 1'b0;
            end else begin
                cls <= cls + 4'd1;
            end
        end
    end

    // The final class is folded in combinationally so the result is ready
    // in the same cycle the last class is examined.
    assign done  = running && (cls == LAST_CLS);
    assign index = cur_wins ? cls : best_idx;
    assign value = cur_wins ? cur_val : best_val;

endmodule

// File: rtl/inference_sequencer.sv
// Runs one network inference per video frame when the canvas changed:
// streams the canvas into the network, waits for it, then picks the digit.
module inference_sequencer #(
    parameter int DIM         = nn_pkg::DIM,
    parameter int PIX_W       = nn_pkg::PIX_W,
    parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter int PROB_W      = nn_pkg::PROB_W,
    parameter int TIMEOUT     = nn_pkg::TIMEOUT_CYCLES
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Frame_Sync,
    input  logic                          Canvas_Dirty,
    input  logic                          Force,
    output logic [9:0]                    Pix_Addr,
    input  logic [PIX_W-1:0]              Pix_Data,
    output logic                          Nn_Start,
    output logic                          Nn_Pix_Valid,
    output logic [PIX_W-1:0]              Nn_Pix_Data,
    input  logic                          Nn_Pix_Ready,
    input  logic                          Nn_Done,
    input  logic [NUM_CLASSES*PROB_W-1:0] Nn_Prob,
    output logic [NUM_CLASSES*PROB_W-1:0] Probability,
    output logic [3:0]                    Digit,
    output logic                          Result_Valid,
    output logic                          Result_Pulse,
    output logic                          Busy,
    output logic                          Timeout_Err
);

    import nn_pkg::*;

    localparam int              PIX_COUNT = DIM * DIM;
    localparam logic [9:0]      PIX_END   = 10'(PIX_COUNT);
    localparam int              WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

    seq_state_t      state;
    seq_state_t      state_next;
    logic            frame_prev;
    logic            pending;
    logic [9:0]      pix_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            argmax_start;
    logic            argmax_done;
    logic [3:0]      argmax_index;
    logic [PROB_W-1:0] unused_argmax_value;

    logic frame_edge;
    logic enter_load;
    logic issue;
    logic last_beat;
    logic nn_finished;
    logic wd_expired;

    assign frame_edge  = frame_prev && !Frame_Sync;
    assign enter_load  = (state == IDLE) && frame_edge && pending;
    assign issue       = (state == LOAD) && (pix_cnt != PIX_END)
                         && (!Nn_Pix_Valid || Nn_Pix_Ready);
    assign last_beat   = (state == LOAD) && (pix_cnt == PIX_END)
                         && Nn_Pix_Valid && Nn_Pix_Ready;
    assign nn_finished = (state == WAIT_NN) && Nn_Done;
    assign wd_expired  = (state == WAIT_NN) && !Nn_Done && (wd_cnt == WD_LAST);

    assign Pix_Addr = pix_cnt;
    assign Busy     = (state != IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enter_load)  state_next = LOAD;
            LOAD:    if (last_beat)   state_next = WAIT_NN;
            WAIT_NN: begin
                if (nn_finished) begin
                    state_next = ARGMAX;
                end else if (wd_expired) begin
                    state_next = IDLE;
                end
            end
            ARGMAX:  if (argmax_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new request in the same cycle as LOAD entry must survive the clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_prev <= 1'b1;
            pending    <= 1'b0;
        end else begin
            frame_prev <= Frame_Sync;
            if (Canvas_Dirty || Force) begin
                pending <= 1'b1;
            end else if (enter_load) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Nn_Start     <= 1'b0;
            pix_cnt      <= '0;
            Nn_Pix_Valid <= 1'b0;
            Nn_Pix_Data  <= '0;
        end else begin
            Nn_Start <= enter_load;
            if (enter_load) begin
                pix_cnt <= '0;
            end else if (issue) begin
                Nn_Pix_Data  <= Pix_Data;
                Nn_Pix_Valid <= 1'b1;
                pix_cnt      <= pix_cnt + 10'd1;
            end else if (last_beat) begin
                Nn_Pix_Valid <= 1'b0;
            end
        end
    end

    // Watchdog only runs while waiting; results are left untouched on expiry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wd_cnt       <= '0;
            Timeout_Err  <= 1'b0;
            Probability  <= '0;
            argmax_start <= 1'b0;
            Digit        <= '0;
            Result_Valid <= 1'b0;
            Result_Pulse <= 1'b0;
        end else begin
            wd_cnt       <= (state == WAIT_NN) ? wd_cnt + WD_W'(1) : '0;
            argmax_start <= nn_finished;
            Result_Pulse <= 1'b0;
            if (wd_expired) begin
                Timeout_Err <= 1'b1;
            end
            if (nn_finished) begin
                Probability <= Nn_Prob;
            end
            if ((state == ARGMAX) && argmax_done) begin
                Digit        <= argmax_index;
                Result_Valid <= 1'b1;
                Result_Pulse <= 1'b1;
            end
        end
    end

    prob_argmax #(
        .NUM_CLASSES (NUM_CLASSES),
        .PROB_W      (PROB_W)
    ) u_argmax (
        .clk   (Clk),
        .rst   (Reset),
        .start (argmax_start),
        .prob  (Probability),
        .done  (argmax_done),
        .index (argmax_index),
        .value (unused_argmax_value)
    );

endmodule

// File: tb/tb_inference_sequencer.sv
// Scoreboard bench for inference_sequencer: stimulus queues expected pixels
// and digits, a negedge monitor pops and compares them as the DUT emits.
module tb_inference_sequencer;

    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_sync = 1'b1;
    logic         canvas_dirty = 1'b0;
    logic         force_req = 1'b0;
    logic         nn_pix_ready = 1'b1;
    logic         nn_done = 1'b0;
    logic [159:0] nn_prob = '0;
    logic [9:0]   pix_addr;
    logic [15:0]  pix_data;
    logic         nn_start;
    logic         nn_pix_valid;
    logic [15:0]  nn_pix_data;
    logic [159:0] probability;
    logic [3:0]   digit;
    logic         result_valid;
    logic         result_pulse;
    logic         busy;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    int total_beats = 0;

    logic [15:0] exp_pix[$];
    logic [3:0]  exp_digit[$];

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_pulse = 1'b0;

    always #5 clk = ~clk;

    // Canvas contents: a bijective function of the address, so any skipped,
    // repeated or reordered pixel shows up as a wrong value.
    function automatic logic [15:0] pix_model(input logic [9:0] a);
        return (16'(a) * 16'd37) ^ 16'h5A5A;
    endfunction

    function automatic logic [159:0] make_vec(input logic [15:0] base, input int ia,
                                              input logic [15:0] va, input int ib,
                                              input logic [15:0] vb);
        logic [159:0] v;
        for (int k = 0; k < 10; k++) begin
            v[k*16 +: 16] = (k == ia) ? va : ((k == ib) ? vb : base);
        end
        return v;
    endfunction

    assign pix_data = pix_model(pix_addr);

    inference_sequencer #(
        .TIMEOUT (TMO)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .Frame_Sync   (frame_sync),
        .Canvas_Dirty (canvas_dirty),
        .Force        (force_req),
        .Pix_Addr     (pix_addr),
        .Pix_Data     (pix_data),
        .Nn_Start     (nn_start),
        .Nn_Pix_Valid (nn_pix_valid),
        .Nn_Pix_Data  (nn_pix_data),
        .Nn_Pix_Ready (nn_pix_ready),
        .Nn_Done      (nn_done),
        .Nn_Prob      (nn_prob),
        .Probability  (probability),
        .Digit        (digit),
        .Result_Valid (result_valid),
        .Result_Pulse (result_pulse),
        .Busy         (busy),
        .Timeout_Err  (timeout_err)
    );

    task automatic checkOutput(input string name, input logic [159:0] act,
                               input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every handshake and every result pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_pulse <= 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                checkOutput("hold_valid", 160'(nn_pix_valid), 160'(1));
                checkOutput("hold_data", 160'(nn_pix_data), 160'(prev_data));
            end
            if (nn_pix_valid && nn_pix_ready) begin
                total_beats <= total_beats + 1;
                if (exp_pix.size() == 0) failNow("extra_beat");
                else checkOutput("pixel", 160'(nn_pix_data), 160'(exp_pix.pop_front()));
            end
            if (result_pulse) begin
                checkOutput("pulse_width", 160'(prev_pulse), 160'(0));
                if (exp_digit.size() == 0) failNow("extra_result");
                else checkOutput("digit", 160'(digit), 160'(exp_digit.pop_front()));
            end
            prev_valid <= nn_pix_valid;
            prev_ready <= nn_pix_ready;
            prev_data  <= nn_pix_data;
            prev_pulse <= result_pulse;
        end
    end

    // Request, frame edge and full canvas stream; returns at the negedge of
    // the first WAIT_NN cycle.
    task automatic applyStimulus(input bit use_force, input bit bp);
        int  beats_start;
        int  stalls;
        bit  seen;
        bit  ok;
        tick();
        if (use_force) force_req = 1'b1;
        else canvas_dirty = 1'b1;
        tick();
        force_req    = 1'b0;
        canvas_dirty = 1'b0;
        nn_pix_ready = 1'b1;
        for (int i = 0; i < 784; i++) exp_pix.push_back(pix_model(10'(i)));
        tick();
        frame_sync = 1'b0;
        @(negedge clk);
        checkOutput("start_before_edge", 160'(nn_start), 160'(0));
        tick();
        frame_sync = 1'b1;
        @(negedge clk);
        checkOutput("start_pulse", 160'(nn_start), 160'(1));
        checkOutput("busy_load", 160'(busy), 160'(1));
        checkOutput("valid_e1", 160'(nn_pix_valid), 160'(0));
        beats_start = total_beats;
        stalls = 0;
        seen = 1'b0;
        ok = 1'b0;
        for (int cyc = 2; cyc < 3000; cyc++) begin
            tick();
            if (bp) nn_pix_ready = ~nn_pix_ready;
            @(negedge clk);
            if (cyc == 2) begin
                checkOutput("first_valid", 160'(nn_pix_valid), 160'(1));
                checkOutput("start_one_cycle", 160'(nn_start), 160'(0));
            end
            if (nn_pix_valid) begin
                seen = 1'b1;
                if (!nn_pix_ready) stalls++;
            end else if (seen) begin
                checkOutput("wait_entry_cycle", 160'(cyc), 160'(786 + stalls));
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNow("load_bound");
        nn_pix_ready = 1'b1;
        checkOutput("beat_count", 160'(total_beats - beats_start), 160'(784));
        checkOutput("queue_drained", 160'(exp_pix.size()), 160'(0));
        checkOutput("busy_wait", 160'(busy), 160'(1));
    endtask

    task automatic applyDone(input logic [159:0] prob, input logic [3:0] exp_d);
        int pulses;
        exp_digit.push_back(exp_d);
        tick();
        tick();
        nn_prob = prob;
        nn_done = 1'b1;
        @(negedge clk);
        tick();
        nn_done = 1'b0;
        nn_prob = ~prob;
        @(negedge clk);
        checkOutput("prob_latched", probability, prob);
        checkOutput("busy_argmax", 160'(busy), 160'(1));
        pulses = 0;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            if (result_pulse) pulses++;
        end
        checkOutput("pulse_early", 160'(pulses), 160'(0));
        checkOutput("busy_d10", 160'(busy), 160'(1));
        @(negedge clk);
        checkOutput("result_pulse", 160'(result_pulse), 160'(1));
        checkOutput("digit_d11", 160'(digit), 160'(exp_d));
        checkOutput("idle_d11", 160'(busy), 160'(0));
        checkOutput("result_valid", 160'(result_valid), 160'(1));
        @(negedge clk);
        checkOutput("pulse_single", 160'(result_pulse), 160'(0));
        checkOutput("digit_queue", 160'(exp_digit.size()), 160'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_time_limit");
        $fatal(1, "[TB] run did not finish");
    end

    initial begin
        logic [159:0] vec_tie;
        logic [159:0] vec_b;
        logic [159:0] vec_c;
        bit seen;
        int base;
        int n;
        vec_tie = make_vec(16'h0100, 3, 16'h7F00, 7, 16'h7F00);
        vec_b   = make_vec(16'h7FFF, 2, 16'h8000, 9, 16'h9000);
        vec_c   = make_vec(16'hFFFE, 0, 16'hFFFF, 0, 16'hFFFF);

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 160'(busy), 160'(0));
        checkOutput("reset_outputs", {nn_start, nn_pix_valid, result_valid, result_pulse,
                    timeout_err, digit, pix_addr, nn_pix_data}, '0);
        checkOutput("reset_prob", probability, '0);

        seen = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            frame_sync = 1'b0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (k == 1) frame_sync = 1'b1;
                @(negedge clk);
                if (busy || nn_start) seen = 1'b1;
            end
        end
        checkOutput("clean_canvas_idle", 160'(seen), 160'(0));

        $display("[TB] dirty canvas, tie between classes 3 and 7");
        applyStimulus(1'b0, 1'b0);
        applyDone(vec_tie, 4'd3);

        $display("[TB] forced inference, maximum in class 0");
        applyStimulus(1'b1, 1'b0);
        applyDone(vec_c, 4'd0);

        $display("[TB] backpressure, unsigned maximum in class 9");
        applyStimulus(1'b0, 1'b1);
        applyDone(vec_b, 4'd9);

        $display("[TB] watchdog expiry");
        applyStimulus(1'b0, 1'b0);
        checkOutput("timeout_before", 160'(timeout_err), 160'(0));
        n = 0;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            if (timeout_err) begin
                n = c;
                break;
            end
        end
        checkOutput("timeout_cycles", 160'(n), 160'(TMO));
        checkOutput("timeout_idle", 160'(busy), 160'(0));
        checkOutput("timeout_result_valid", 160'(result_valid), 160'(1));
        checkOutput("timeout_digit", 160'(digit), 160'(9));
        tick();
        nn_prob = vec_c;
        nn_done = 1'b1;
        tick();
        nn_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("done_ignored_prob", probability, vec_b);
        checkOutput("done_ignored_busy", 160'(busy), 160'(0));

        $display("[TB] reset during load");
        tick();
        canvas_dirty = 1'b1;
        tick();
        canvas_dirty = 1'b0;
        for (int i = 0; i < 784; i++) exp_pix.push_back(pix_model(10'(i)));
        tick();
        frame_sync = 1'b0;
        tick();
        frame_sync = 1'b1;
        base = total_beats;
        n = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (total_beats - base >= 400) begin
                n = 1;
                break;
            end
        end
        if (n == 0) failNow("reset_load_bound");
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midload_reset_busy", 160'(busy), 160'(0));
        checkOutput("midload_reset_outputs", {nn_start, nn_pix_valid, result_valid, result_pulse,
                    timeout_err, digit, pix_addr, nn_pix_data}, '0);
        checkOutput("midload_reset_prob", probability, '0);
        exp_pix.delete();
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] inference after reset restarts at pixel 0");
        applyStimulus(1'b0, 1'b0);
        applyDone(vec_tie, 4'd3);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Schedules one neural-network inference per video frame when the 28x28 drawing canvas has changed. Sits between `canvas_editor`, `vga_controller` and `neural_network`: detects the frame boundary and streams the 784 canvas pixels into the network over a valid/ready handshake. It then waits for completion, latches the ten class probabilities and computes the predicted digit for the HEX/LED display path.

## Interface
- `DIM`, 28: canvas side length; pixel count `NUM_PIX` = `DIM*DIM` = 784.
- `PIX_W`, 16: canvas pixel width.
- `NUM_CLASSES`, 10: output classes.
- `PROB_W`, 16: probability width, unsigned.
- `TIMEOUT`, 1048576: maximum cycles to wait for `Nn_Done`.

Ports:
- `Clk` in 1: system clock (50 MHz); the only clock.
- `Reset` in 1: asynchronous, active-high reset.
- `Frame_Sync` in 1: VGA vertical sync, active-low, generated in `Clk` domain.
- `Canvas_Dirty` in 1: level, high while the canvas is being edited.
- `Force` in 1: request an inference at the next frame even if the canvas is clean.
- `Pix_Addr` out 10: canvas read index, row*DIM+col.
- `Pix_Data` in PIX_W: canvas value at `Pix_Addr`, combinational with zero latency.
- `Nn_Start` out 1: one-cycle start pulse to the network.
- `Nn_Pix_Valid` out 1, `Nn_Pix_Data` out PIX_W: pixel stream to the network.
- `Nn_Pix_Ready` in 1: network accepts the pixel.
- `Nn_Done` in 1: network finished.
- `Nn_Prob` in NUM_CLASSES*PROB_W: packed probabilities; class k occupies bits [k*PROB_W +: PROB_W].
- `Probability` out NUM_CLASSES*PROB_W: latched probabilities.
- `Digit` out 4: argmax class.
- `Result_Valid` out 1: sticky; high once any inference has completed.
- `Result_Pulse` out 1: one cycle per completed result.
- `Busy` out 1: high in any state other than IDLE.
- `Timeout_Err` out 1: sticky; set when the wait for `Nn_Done` expires.

## Operation
States: IDLE, LOAD, WAIT_NN, ARGMAX.

- **Pending flag**
  - Set on any cycle where `Canvas_Dirty` or `Force` is high.
  - Cleared on the cycle LOAD is entered.
  - A set during the same cycle as LOAD entry wins, so the flag stays high.
- **Frame edge**
  - Registered `Frame_Sync` is compared with the current input.
  - A falling edge is prev=1, cur=0.
- **IDLE -> LOAD**
  - Condition: frame edge and pending flag set.
  - Actions on entry: `Nn_Start`=1 for exactly one cycle; pixel counter cleared to 0.
  - A frame edge with pending clear keeps the block in IDLE.
- **LOAD**
  - `Pix_Addr` = pixel counter.
  - The output register loads `Pix_Data` and sets `Nn_Pix_Valid` when the register is empty or `Nn_Pix_Ready` is high; the counter then increments.
  - `Nn_Pix_Data` and `Nn_Pix_Valid` hold while valid is high and ready is low.
  - The counter stops issuing at 784.
  - After the 784th handshake (index 783): valid drops and the state goes to WAIT_NN.
- **WAIT_NN**
  - The watchdog counts cycles.
  - `Nn_Done`=1: latch `Nn_Prob` into `Probability`, go to ARGMAX.
  - Watchdog reaching `TIMEOUT`: set `Timeout_Err`, go to IDLE; `Probability`, `Digit` and `Result_Valid` are unchanged.
  - `Nn_Done` in any other state is ignored.
- **ARGMAX**
  - Walks classes 0..9, one per cycle, with an unsigned compare.
  - Strictly greater replaces the current best, so ties resolve to the lowest index.
  - After class 9: update `Digit`, set `Result_Valid`, pulse `Result_Pulse`, return to IDLE.
- **Reset mid-operation**: immediate return to IDLE; the in-flight inference is abandoned.

Reset values: every output is 0, the pending flag is 0, and the registered `Frame_Sync` is 1.

## Timing
- Edge detected in cycle E: state is LOAD and `Nn_Start`=1 in cycle E+1.
- First `Nn_Pix_Valid` with pixel 0 in cycle E+2.
- With `Nn_Pix_Ready` held high, one pixel per cycle; the last pixel is valid in cycle E+785 and WAIT_NN is entered at E+786.
- `Nn_Done` sampled high in cycle D: `Probability` updated and ARGMAX entered at D+1.
- `Digit` and `Result_Pulse` appear at D+11; IDLE at D+11.
- `Busy` is high from E+1 through D+10.
- Backpressure adds exactly one cycle per ready-low cycle while valid is high.
- A frame edge while not in IDLE is not queued, but the pending flag persists, so the inference runs at the next edge.

## Structure
- Shared package `nn_pkg`:
  - `DIM`, `NUM_PIX`, `NUM_CLASSES`, `PROB_W`, `PIX_W`.
  - Enum `seq_state_t` {IDLE, LOAD, WAIT_NN, ARGMAX}.
  - `prob_vec_t` packed type for the probability vector.
- One sub-module, `prob_argmax`: sequential argmax with start, done, index and value.
- The FSM, pixel streamer and watchdog stay in the top of this block.

## Test plan
- **Clean canvas:**
  - Stimulus: `Canvas_Dirty`=0, `Force`=0, three frame edges.
  - Required: `Busy` and `Nn_Start` never assert.
- **Dirty canvas, ready always high:**
  - Stimulus: one dirty cycle, then an edge at cycle E.
  - Required: `Nn_Start` at E+1; exactly 784 handshakes with `Nn_Pix_Data` = `Pix_Data` at indices 0..783, in order.
- **Backpressure:**
  - Stimulus: `Nn_Pix_Ready` toggled 1/0 every cycle.
  - Required: data held stable while stalled; no pixel dropped or duplicated; 784 beats total.
- **Argmax with a tie:**
  - Stimulus: `Nn_Prob` class 3 = 0x7F00, class 7 = 0x7F00, others 0x0100, then `Nn_Done`.
  - Required: `Digit`=3 eleven cycles later; `Result_Pulse` for exactly one cycle.
- **Timeout:**
  - Stimulus: `Nn_Done` never asserted.
  - Required: `Timeout_Err`=1 after `TIMEOUT` cycles in WAIT_NN; IDLE; `Result_Valid` unchanged.
- **Reset during LOAD:**
  - Stimulus: `Reset` at pixel 400.
  - Required: all outputs 0 immediately; the next dirty edge restarts from pixel 0.
